// File: rtl/gb_link_target.sv
// Link-port target: synchronizes an externally clocked serial link and moves one byte in
// each direction per transfer, MSB first, with an optional mid-byte stall timeout.
module gb_link_target #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       SerialClkIn,
    input  logic       SerialDataIn,
    output logic       SerialDataOut,
    input  logic [7:0] TxData,
    input  logic       Start,
    output logic       Busy,
    output logic [7:0] RxData,
    output logic       RxValid,
    output logic       Abort
);

    localparam int          STAGES        = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);
    localparam logic [15:0] TIMEOUT_LAST  = TIMEOUT_LIMIT - 16'd1;

    typedef enum logic {IDLE, ACTIVE} stateT;

    stateT              state;
    logic [STAGES-1:0]  clkSync;
    logic [STAGES-1:0]  dataSync;
    logic               clkDly;
    logic [2:0]         bitCnt;
    logic [7:0]         shiftReg;
    logic [15:0]        toCnt;
    logic               linkRise;
    logic               linkFall;
    logic [7:0]         shiftNext;

    // Synchronizers reset to the idle-high level so releasing reset with the link
    // clock high never looks like an edge.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            clkSync  <= '1;
            dataSync <= '1;
            clkDly   <= 1'b1;
        end else begin
            clkSync  <= {clkSync[STAGES-2:0], SerialClkIn};
            dataSync <= {dataSync[STAGES-2:0], SerialDataIn};
            clkDly   <= clkSync[STAGES-1];
        end
    end

    assign linkRise  = clkSync[STAGES-1] & ~clkDly;
    assign linkFall  = ~clkSync[STAGES-1] & clkDly;
    assign shiftNext = {shiftReg[6:0], dataSync[STAGES-1]};

    // Handshake: Start is a one-cycle strobe honoured only while Busy is low; RxValid and
    // Abort are mutually exclusive one-cycle pulses, both coinciding with Busy falling.
    // Busy is the FSM state (high exactly in ACTIVE).
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state         <= IDLE;
            bitCnt        <= 3'd0;
            toCnt         <= 16'd0;
            shiftReg      <= 8'h00;
            RxData        <= 8'h00;
            RxValid       <= 1'b0;
            Abort         <= 1'b0;
            Busy          <= 1'b0;
            SerialDataOut <= 1'b1;
        end else begin
            RxValid <= 1'b0;
            Abort   <= 1'b0;
            case (state)
                IDLE: begin
                    SerialDataOut <= 1'b1;
                    if (Start) begin
                        shiftReg <= TxData;
                        bitCnt   <= 3'd0;
                        toCnt    <= 16'd0;
                        state    <= ACTIVE;
                        Busy     <= 1'b1;
                    end
                end
                ACTIVE: begin
                    if (linkRise) begin
                        shiftReg <= shiftNext;
                        bitCnt   <= bitCnt + 3'd1;
                        toCnt    <= 16'd0;
                        if (bitCnt == 3'd7) begin
                            RxData        <= shiftNext;
                            RxValid       <= 1'b1;
                            state         <= IDLE;
                            Busy          <= 1'b0;
                            SerialDataOut <= 1'b1;
                        end
                    end else if (linkFall) begin
                        SerialDataOut <= shiftReg[7];
                        toCnt         <= 16'd0;
                    end else if (bitCnt != 3'd0) begin
                        // Before the first bit the master may take as long as it likes.
                        if (TIMEOUT_LIMIT != 16'd0 && toCnt == TIMEOUT_LAST) begin
                            Abort         <= 1'b1;
                            state         <= IDLE;
                            Busy          <= 1'b0;
                            SerialDataOut <= 1'b1;
                            toCnt         <= 16'd0;
                        end else if (toCnt != 16'hFFFF) begin
                            toCnt <= toCnt + 16'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
